// File: rtl/lifo_stack_pkg.sv
// Shared command encoding for the parameterised LIFO stack.
package lifo_stack_pkg;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_e;

endpackage

// File: rtl/lifo_mod_ptr.sv
// Modulo-DEPTH pointer arithmetic: ptr_out = (ptr_in +/- offset) mod DEPTH.
// ptr_in must already be below DEPTH; offsets of DEPTH or more act as zero.
module lifo_mod_ptr #(
    parameter int DEPTH = 5,
    parameter int OW    = 1,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic [PW-1:0] ptr_in,
    input  logic [OW-1:0] offset,
    input  logic          sub,
    output logic [PW-1:0] ptr_out
);

    // One spare bit above the wider operand keeps ptr + DEPTH from overflowing.
    localparam int EW = ((PW > OW) ? PW : OW) + 1;

    logic [EW-1:0] base;
    logic [EW-1:0] off;
    logic [EW-1:0] res;

    always_comb begin
        base = EW'(ptr_in);
        off  = (EW'(offset) >= EW'(DEPTH)) ? '0 : EW'(offset);
        res  = '0;
        if (sub) begin
            if (off > base) begin
                res = base + EW'(DEPTH) - off;
            end else begin
                res = base - off;
            end
        end else begin
            res = base + off;
            if (res >= EW'(DEPTH)) begin
                res = res - EW'(DEPTH);
            end
        end
        ptr_out = res[PW-1:0];
    end

endmodule

// File: rtl/lifo_stack_param.sv
// Circular-buffer LIFO with PUSH/POP/GET commands and a one-deep output register
// guarded by a valid/ready handshake.
module lifo_stack_param
    import lifo_stack_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5,
    parameter int WRAP  = 1,
    parameter int IW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [1:0]       CMD,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [WIDTH-1:0] DIN,
    input  logic [IW-1:0]    INDEX,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic [CW-1:0]    COUNT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ERR
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]    top_q, top_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic             err_q, err_d;
    logic             wr_en;
    logic             accept;
    logic             full, empty;
    logic [IW-1:0]    top_step;
    logic [IW-1:0]    get_addr;
    cmd_e             cmd;

    assign cmd       = cmd_e'(CMD);
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign CMD_READY = !dout_valid_q || DOUT_READY;
    assign accept    = CMD_VALID && CMD_READY;

    // Neighbouring slot of the top: above it for PUSH, below it for POP.
    lifo_mod_ptr #(.DEPTH(DEPTH), .OW(1)) u_top_ptr (
        .ptr_in (top_q),
        .offset (1'b1),
        .sub    (cmd == CMD_POP),
        .ptr_out(top_step)
    );

    lifo_mod_ptr #(.DEPTH(DEPTH), .OW(IW)) u_get_ptr (
        .ptr_in (top_q),
        .offset (INDEX),
        .sub    (1'b1),
        .ptr_out(get_addr)
    );

    always_comb begin
        top_d        = top_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q && !DOUT_READY;
        err_d        = 1'b0;
        wr_en        = 1'b0;
        if (accept) begin
            case (cmd)
                CMD_PUSH: begin
                    if (full && (WRAP == 0)) begin
                        err_d = 1'b1;
                    end else begin
                        // When full the slot above top is the oldest entry, so it is overwritten.
                        top_d = top_step;
                        wr_en = 1'b1;
                        if (!full) begin
                            count_d = count_q + CW'(1);
                        end
                    end
                end
                CMD_POP: begin
                    if (empty) begin
                        err_d = 1'b1;
                    end else begin
                        dout_d       = mem[top_q];
                        dout_valid_d = 1'b1;
                        top_d        = top_step;
                        count_d      = count_q - CW'(1);
                    end
                end
                CMD_GET: begin
                    if (CW'(INDEX) >= count_q) begin
                        err_d = 1'b1;
                    end else begin
                        dout_d       = mem[get_addr];
                        dout_valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            top_q        <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            top_q        <= top_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            err_q        <= err_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET && wr_en) begin
            mem[top_step] <= DIN;
        end
    end

    assign DOUT       = dout_q;
    assign DOUT_VALID = dout_valid_q;
    assign COUNT      = count_q;
    assign FULL       = full;
    assign EMPTY      = empty;
    assign ERR        = err_q;

endmodule

// File: tb/tb_lifo_stack_param.sv
// Scoreboard bench for lifo_stack_param: one WRAP=1 and one WRAP=0 instance,
// each checked against a queue-based stack model.
module tb_lifo_stack_param;

    localparam int W  = 4;
    localparam int D  = 5;
    localparam int IW = 3;
    localparam int CW = 3;

    localparam logic [1:0] C_NOP  = 2'b00;
    localparam logic [1:0] C_PUSH = 2'b01;
    localparam logic [1:0] C_POP  = 2'b10;
    localparam logic [1:0] C_GET  = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_s   [2];
    logic [1:0]    cmd_s   [2];
    logic          cv_s    [2];
    logic          cr_s    [2];
    logic [W-1:0]  din_s   [2];
    logic [IW-1:0] idx_s   [2];
    logic [W-1:0]  dout_s  [2];
    logic          dv_s    [2];
    logic          dr_s    [2];
    logic [CW-1:0] cnt_s   [2];
    logic          full_s  [2];
    logic          empty_s [2];
    logic          err_s   [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        lifo_stack_param #(.WIDTH(W), .DEPTH(D), .WRAP((gi == 0) ? 1 : 0)) u_dut (
            .CLK       (clk),
            .RESET     (rst_s[gi]),
            .CMD       (cmd_s[gi]),
            .CMD_VALID (cv_s[gi]),
            .CMD_READY (cr_s[gi]),
            .DIN       (din_s[gi]),
            .INDEX     (idx_s[gi]),
            .DOUT      (dout_s[gi]),
            .DOUT_VALID(dv_s[gi]),
            .DOUT_READY(dr_s[gi]),
            .COUNT     (cnt_s[gi]),
            .FULL      (full_s[gi]),
            .EMPTY     (empty_s[gi]),
            .ERR       (err_s[gi])
        );
    end

    // Model: front of stk is the top of stack.
    int stk      [2][$];
    int exp_dout [2][$];
    int exp_err  [2][$];
    bit pend     [2];
    bit post_rst [2];
    bit mon_en = 1'b0;
    int edge_cnt = 0;
    int chk_cnt = 0;
    int err_cnt = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s dut%0d: got %0d expected %0d", name, i, act, exp);
        end
    endtask

    // Monitor: compares ERR timing and every presented result against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                bit e_exp;
                e_exp = 1'b0;
                check("dout_valid", i, 32'(dv_s[i]), 32'(pend[i]));
                if (exp_err[i].size() > 0 && exp_err[i][0] == edge_cnt) begin
                    e_exp = 1'b1;
                    void'(exp_err[i].pop_front());
                end
                check("err", i, 32'(err_s[i]), 32'(e_exp));
                if (dv_s[i] === 1'b1) begin
                    if (exp_dout[i].size() == 0) begin
                        chk_cnt++;
                        err_cnt++;
                        $display("FAIL dout dut%0d: got %0d while no result expected", i, dout_s[i]);
                    end else begin
                        check("dout", i, 32'(dout_s[i]), 32'(exp_dout[i][0]));
                        if (dr_s[i]) void'(exp_dout[i].pop_front());
                    end
                end
            end
        end
    end

    // One clock of stimulus on instance i, entered and left at posedge+1.
    task automatic cycle(input int i, input bit r, input logic [1:0] c, input bit v,
                         input int d, input int idx, input bit rdy);
        bit exp_rdy, acc, res_ok, rej;
        int res;
        rst_s[i] = r; cmd_s[i] = c; cv_s[i] = v;
        din_s[i] = W'(d); idx_s[i] = IW'(idx); dr_s[i] = rdy;
        #1;
        exp_rdy = !pend[i] || rdy;
        check("cmd_ready", i, 32'(cr_s[i]), 32'(exp_rdy));
        check("count", i, 32'(cnt_s[i]), stk[i].size());
        check("full", i, 32'(full_s[i]), 32'(stk[i].size() == D));
        check("empty", i, 32'(empty_s[i]), 32'(stk[i].size() == 0));
        if (post_rst[i]) check("dout_after_reset", i, 32'(dout_s[i]), 0);
        acc = v && exp_rdy && !r;
        @(posedge clk);
        #1;
        post_rst[i] = r;
        res_ok = 1'b0; rej = 1'b0; res = 0;
        if (r) begin
            stk[i].delete(); exp_dout[i].delete(); exp_err[i].delete();
            pend[i] = 1'b0;
            $display("dut%0d edge %0d RESET", i, edge_cnt);
        end else begin
            pend[i] = pend[i] && !rdy;
            if (acc) begin
                case (c)
                    C_PUSH: begin
                        if (stk[i].size() < D) stk[i].push_front(d % 16);
                        else if (i == 0) begin void'(stk[i].pop_back()); stk[i].push_front(d % 16); end
                        else rej = 1'b1;
                    end
                    C_POP: begin
                        if (stk[i].size() == 0) rej = 1'b1;
                        else begin res = stk[i].pop_front(); res_ok = 1'b1; end
                    end
                    C_GET: begin
                        if (idx >= stk[i].size()) rej = 1'b1;
                        else begin res = stk[i][idx]; res_ok = 1'b1; end
                    end
                    default: ;
                endcase
                if (rej) exp_err[i].push_back(edge_cnt);
                if (res_ok) begin exp_dout[i].push_back(res); pend[i] = 1'b1; end
                $display("dut%0d edge %0d cmd=%0d din=%0d idx=%0d rdy=%0d %s res=%0d", i, edge_cnt,
                         c, d, idx, rdy, rej ? "rejected" : "done", res);
            end
        end
    endtask

    task automatic push(input int i, input int d);    cycle(i, 0, C_PUSH, 1, d, 0, 1);   endtask
    task automatic pop(input int i, input bit rdy);    cycle(i, 0, C_POP, 1, 0, 0, rdy);  endtask
    task automatic get(input int i, input int idx);    cycle(i, 0, C_GET, 1, 0, idx, 1);  endtask
    task automatic idle(input int i);                  cycle(i, 0, C_NOP, 0, 0, 0, 1);    endtask
    task automatic reset(input int i);                 cycle(i, 1, C_NOP, 0, 0, 0, 1);    endtask

    task automatic random_run(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            int sel;
            logic [1:0] c;
            sel = $urandom_range(0, 99);
            c = (sel < 40) ? C_PUSH : (sel < 65) ? C_POP : (sel < 90) ? C_GET : C_NOP;
            cycle(i, $urandom_range(0, 63) == 0, c, $urandom_range(0, 9) < 8,
                  $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 9) < 7);
        end
        idle(i); idle(i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b1; cmd_s[i] = C_NOP; cv_s[i] = 1'b0;
            din_s[i] = '0; idx_s[i] = '0; dr_s[i] = 1'b1;
            pend[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            rst_s[i] = 1'b0;
            post_rst[i] = 1'b1;
        end
        mon_en = 1'b1;

        // LIFO order with immediate consumption
        push(0, 1); push(0, 2); push(0, 3);
        pop(0, 1); pop(0, 1); pop(0, 1); idle(0);

        // Overwrite of oldest on full, then GET down the stack
        reset(0);
        for (int v = 1; v <= 7; v++) push(0, v);
        for (int k = 0; k < 5; k++) get(0, k);
        idle(0);

        // Rejections on empty and out-of-range GET
        reset(0);
        pop(0, 1); push(0, 9); get(0, 1); get(0, 0); get(0, 7); idle(0);

        // Back-pressure: result held, then lossless handshake + new pop
        reset(0);
        push(0, 4); push(0, 8); pop(0, 0);
        pop(0, 0); pop(0, 0); pop(0, 0);
        pop(0, 1); idle(0); idle(0);

        // Reset discards a pending result
        push(0, 5); pop(0, 0);
        cycle(0, 1, C_POP, 1, 0, 0, 0);
        idle(0);

        random_run(0, 300);

        // Non-wrapping instance: push on full is rejected
        reset(1);
        for (int v = 1; v <= 6; v++) push(1, v);
        pop(1, 1); idle(1);
        random_run(1, 300);

        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("results_left", i, exp_dout[i].size(), 0);
            check("errs_left", i, exp_err[i].size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/lifo_stack_param.md
LIFO_STACK_PARAM -- requirements
Module: lifo_stack_param

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 5, number of entries (>=2; not required to be a power of two).
REQ-003 SHALL have parameter WRAP, default 1: 1 = push on full overwrites the oldest entry; 0 = push on full is rejected.
REQ-004 SHALL have port CLK  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port CMD  input  2  command: 00 NOP, 01 PUSH, 10 POP, 11 GET.
REQ-007 SHALL have port CMD_VALID  input  1  CMD, DIN and INDEX are valid.
REQ-008 SHALL have port CMD_READY  output  1  block can accept a command this cycle.
REQ-009 SHALL have port DIN  input  WIDTH  push data.
REQ-010 SHALL have port INDEX  input  clog2(DEPTH)  GET depth; 0 = top, k = k-th entry below top.
REQ-011 SHALL have port DOUT  output  WIDTH  POP/GET result.
REQ-012 SHALL have port DOUT_VALID  output  1  DOUT holds an unconsumed result.
REQ-013 SHALL have port DOUT_READY  input  1  consumer accepts DOUT this cycle.
REQ-014 SHALL have port COUNT  output  clog2(DEPTH+1)  number of valid entries, 0..DEPTH.
REQ-015 SHALL have ports FULL and EMPTY  output  1 each  COUNT==DEPTH and COUNT==0.
REQ-016 SHALL have port ERR  output  1  one-cycle pulse on a rejected command.

Function
REQ-017 A command SHALL be accepted on a rising CLK where CMD_VALID && CMD_READY; otherwise no state changes.
REQ-018 CMD_READY SHALL be combinational: !DOUT_VALID || DOUT_READY.
REQ-019 DOUT_VALID SHALL rise the cycle after an accepted successful POP/GET, hold DOUT stable while DOUT_VALID && !DOUT_READY, and clear after a DOUT_READY handshake unless a new result loads in the same cycle.
REQ-020 Storage SHALL be a circular buffer: top pointer modulo DEPTH, COUNT tracked separately; all pointer arithmetic SHALL wrap at DEPTH with no intermediate overflow.
REQ-021 PUSH, not full: top advances by 1 mod DEPTH, DIN written at new top, COUNT+1.
REQ-022 PUSH, full, WRAP=1: top advances, DIN overwrites the oldest entry, COUNT stays DEPTH, no ERR.
REQ-023 PUSH, full, WRAP=0: no state change, ERR pulses.
REQ-024 POP, not empty: DOUT loads entry at top, top retreats by 1 mod DEPTH, COUNT-1.
REQ-025 POP on empty: no state change, no DOUT_VALID, ERR pulses.
REQ-026 GET with INDEX < COUNT: DOUT loads entry at (top - INDEX) mod DEPTH; pointer and COUNT unchanged.
REQ-027 GET with INDEX >= COUNT (including INDEX >= DEPTH): no state change, no DOUT_VALID, ERR pulses.
REQ-028 NOP SHALL be accepted with no effect.
REQ-029 ERR SHALL be high for exactly the one cycle following the rejected command; otherwise low.
REQ-030 Handshake-out and accept in the same cycle SHALL be lossless: old DOUT consumed, new result loaded, DOUT_VALID stays 1.

Reset
REQ-031 RESET SHALL take precedence over any command in the same cycle.
REQ-032 After RESET: COUNT=0, top pointer=0, EMPTY=1, FULL=0, DOUT=0, DOUT_VALID=0, ERR=0; any pending result SHALL be discarded.
REQ-033 Storage contents need not be cleared; REQ-027 guarantees stale data is never returned.

Structure
REQ-034 Package lifo_stack_pkg SHALL hold the command typedef enum (CMD_NOP, CMD_PUSH, CMD_POP, CMD_GET).
REQ-035 Modulo-DEPTH increment/decrement/subtract SHALL be one sub-module, lifo_mod_ptr, instantiated for top and GET address.

Verification (WIDTH=4, DEPTH=5)
REQ-036 Push 1,2,3; pop x3 with DOUT_READY=1 -> DOUT 3,2,1 one cycle after each pop; COUNT 3->0; EMPTY=1.
REQ-037 WRAP=1: push 1..7; GET INDEX 0..4 -> 7,6,5,4,3; COUNT=5, FULL=1, ERR never high.
REQ-038 WRAP=0: push 1..6 -> 6th push gives ERR pulse, COUNT=5; pop -> 5.
REQ-039 Reset, pop -> ERR pulse, DOUT_VALID=0; push 9, GET INDEX 1 -> ERR; GET INDEX 0 -> 9.
REQ-040 Push 4,8; pop with DOUT_READY=0 -> CMD_READY=0, DOUT=8 held 3 cycles; DOUT_READY=1 with pop pending -> DOUT=4 next cycle, no loss.
REQ-041 Push 5; pop held with DOUT_READY=0, assert RESET -> next cycle DOUT_VALID=0, COUNT=0, DOUT=0.
